// File: rtl/fpdiv_seq.sv
// Sequential floating-point divider: radix-2 restoring mantissa division, one quotient bit per clock.
// Define FPDIV_RNE_EN for round-to-nearest-even (one extra iteration); otherwise results truncate.
module fpdiv_seq #(
  parameter int EXPW = 8,
  parameter int MANW = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EXPW+MANW:0] opa,
  input  logic [EXPW+MANW:0] opb,
  input  logic [EXPW-1:0]    bias,
  output logic               busy,
  output logic               done,
  output logic [EXPW+MANW:0] result,
  output logic               dz,
  output logic               invalid,
  output logic               ovf,
  output logic               unf
);

  localparam int FW = EXPW + MANW + 1;
`ifdef FPDIV_RNE_EN
  localparam int NITER = MANW + 3;
`else
  localparam int NITER = MANW + 2;
`endif
  localparam int CW = $clog2(NITER + 1);

  localparam logic signed [EXPW+1:0] EMAX = {2'b00, {EXPW{1'b1}}};
  localparam logic signed [EXPW+1:0] EONE = {{(EXPW+1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]          QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, NORM, FIN} state_t;
  typedef enum logic [2:0] {CL_NUM, CL_NAN, CL_INV, CL_DZ, CL_INF, CL_ZERO} class_t;

  state_t                  state;
  class_t                  cls;
  class_t                  clsin;
  logic                    sgn;
  logic signed [EXPW+1:0]  expv;
  logic [MANW+1:0]         rem;
  logic [MANW:0]           dvs;
  logic [NITER-1:0]        quo;
  logic [CW-1:0]           cnt;

  logic [EXPW-1:0]         ea, eb;
  logic [MANW-1:0]         ma, mb;
  logic                    azero, ainf, anan, bzero, binf, bnan;

  logic                    geq;
  logic [MANW:0]           diff;

  logic [MANW-1:0]         mann;
  logic signed [EXPW+1:0]  expn;
  logic [FW-1:0]           resn;
  logic                    ovfn, unfn;
`ifdef FPDIV_RNE_EN
  logic                    guard, stk;
  logic [MANW:0]           sum;
`endif

  assign ea = opa[FW-2:MANW];
  assign eb = opb[FW-2:MANW];
  assign ma = opa[MANW-1:0];
  assign mb = opb[MANW-1:0];

  assign azero = (ea == '0);
  assign bzero = (eb == '0);
  assign ainf  = (ea == '1) && (ma == '0);
  assign binf  = (eb == '1) && (mb == '0);
  assign anan  = (ea == '1) && (ma != '0);
  assign bnan  = (eb == '1) && (mb != '0);

  // Operand class is fixed at accept; the divider still runs so latency never depends on it.
  always_comb begin
    clsin = CL_NUM;
    if (anan || bnan)
      clsin = CL_NAN;
    else if ((azero && bzero) || (ainf && binf))
      clsin = CL_INV;
    else if (bzero && !ainf)
      clsin = CL_DZ;
    else if (ainf)
      clsin = CL_INF;
    else if (azero || binf)
      clsin = CL_ZERO;
  end

  // Partial remainder stays below 2*d, so the subtraction result always fits MANW+1 bits.
  assign geq  = (rem >= {1'b0, dvs});
  assign diff = geq ? (rem[MANW:0] - dvs) : rem[MANW:0];

  always_comb begin
    mann = '0;
    expn = expv;
    resn = '0;
    ovfn = 1'b0;
    unfn = 1'b0;
`ifdef FPDIV_RNE_EN
    guard = 1'b0;
    stk   = (rem != '0);
    if (quo[NITER-1]) begin
      mann  = quo[MANW+1:2];
      guard = quo[1];
      stk   = (rem != '0) | quo[0];
    end else begin
      mann  = quo[MANW:1];
      guard = quo[0];
      expn  = expv - EONE;
    end
    sum  = {1'b0, mann} + {{MANW{1'b0}}, guard & (stk | mann[0])};
    mann = sum[MANW-1:0];
    if (sum[MANW])
      expn = expn + EONE;
`else
    if (quo[NITER-1]) begin
      mann = quo[MANW:1];
    end else begin
      mann = quo[MANW-1:0];
      expn = expv - EONE;
    end
`endif
    case (cls)
      CL_NAN, CL_INV: resn = QNAN;
      CL_DZ, CL_INF:  resn = {sgn, {EXPW{1'b1}}, {MANW{1'b0}}};
      CL_ZERO:        resn = {sgn, {(FW-1){1'b0}}};
      default: begin
        if (expn >= EMAX) begin
          resn = {sgn, {EXPW{1'b1}}, {MANW{1'b0}}};
          ovfn = 1'b1;
        end else if (expn[EXPW+1] || (expn == '0)) begin
          resn = {sgn, {(FW-1){1'b0}}};
          unfn = 1'b1;
        end else begin
          resn = {sgn, expn[EXPW-1:0], mann};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cls     <= CL_NUM;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      dz      <= 1'b0;
      invalid <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      sgn     <= 1'b0;
      expv    <= '0;
      rem     <= '0;
      dvs     <= '0;
      quo     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DIV;
            busy    <= 1'b1;
            dz      <= 1'b0;
            invalid <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            cls     <= clsin;
            sgn     <= opa[FW-1] ^ opb[FW-1];
            expv    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed({2'b00, bias});
            rem     <= {2'b01, ma};
            dvs     <= {1'b1, mb};
            quo     <= '0;
            cnt     <= '0;
          end
        end
        DIV: begin
          quo <= {quo[NITER-2:0], geq};
          rem <= {diff, 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NITER - 1))
            state <= NORM;
        end
        NORM: begin
          state   <= FIN;
          done    <= 1'b1;
          result  <= resn;
          dz      <= (cls == CL_DZ);
          invalid <= (cls == CL_INV);
          ovf     <= ovfn;
          unf     <= unfn;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_seq.sv
// Randomised self-checking bench for fpdiv_seq against an arithmetic reference of the divider.
// Honours FPDIV_RNE_EN for the rounding mode and latency it expects.
module tb_fpdiv_seq;

`ifdef FPDIV_RNE_EN
  localparam int          LAT   = 28;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam int          LAT   = 27;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] opa, opb;
  logic [7:0]  bias;
  logic        busy, done, dz, invalid, ovf, unf;
  logic [31:0] result;

  int total;
  int bad;

  fpdiv_seq #(.EXPW(8), .MANW(23)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb), .bias(bias),
    .busy(busy), .done(done), .result(result),
    .dz(dz), .invalid(invalid), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient computed directly as an integer ratio of the significands; flags {dz,invalid,ovf,unf}.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] bs,
                                output logic [31:0] r, output logic [3:0] fl);
    int ea, eb, e;
    longint na, nb, num, q;
`ifdef FPDIV_RNE_EN
    longint rm;
`endif
    logic s, az, bz, ai, bi, an, bn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    fl = 4'b0000;
    r  = 32'h0;
    if (an || bn) begin
      r = 32'h7FC00000;
    end else if ((az && bz) || (ai && bi)) begin
      r = 32'h7FC00000;
      fl[2] = 1'b1;
    end else if (bz && !ai) begin
      r = {s, 8'hFF, 23'h0};
      fl[3] = 1'b1;
    end else if (ai) begin
      r = {s, 8'hFF, 23'h0};
    end else if (az || bi) begin
      r = {s, 31'h0};
    end else begin
      na = 64'h800000 + longint'(a[22:0]);
      nb = 64'h800000 + longint'(b[22:0]);
      e  = ea - eb + int'(bs);
      if (na >= nb) begin
        num = na << 23;
      end else begin
        num = na << 24;
        e = e - 1;
      end
      q = num / nb;
`ifdef FPDIV_RNE_EN
      rm = num % nb;
      if ((2 * rm > nb) || ((2 * rm == nb) && (q % 2 == 1)))
        q = q + 1;
      if (q == 64'h1000000) begin
        q = 64'h800000;
        e = e + 1;
      end
`endif
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        fl[1] = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        fl[0] = 1'b1;
      end else begin
        r = {s, e[7:0], q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] rv;
    int k;
    rv = $urandom();
    k  = int'($urandom_range(0, 11));
    case (k)
      0:       rand_op = {rv[31], 8'h00, rv[22:0]};
      1:       rand_op = {rv[31], 8'hFF, 23'h0};
      2:       rand_op = {rv[31], 8'hFF, rv[22:1], 1'b1};
      3, 4:    rand_op = {rv[31], 8'($urandom_range(1, 254)), rv[22:0]};
      default: rand_op = {rv[31], 8'($urandom_range(80, 175)), rv[22:0]};
    endcase
  endfunction

  // Drives one start at the next falling edge and watches a bounded window for done pulses.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] bs,
                        output logic [31:0] res, output logic [3:0] fl, output int lat,
                        output int ndone, output logic bon, output logic boff);
    res = 32'hxxxxxxxx;
    fl  = 4'bxxxx;
    lat = -1;
    ndone = 0;
    bon = 1'b0;
    boff = 1'b1;
    @(negedge clk);
    opa = a; opb = b; bias = bs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) bon = busy;
      if (c == LAT + 1) boff = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          res = result;
          fl  = {dz, invalid, ovf, unf};
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    opa = '0; opb = '0; bias = 8'd127;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    total++;
    if ({dz, invalid, ovf, unf} !== 4'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {dz, invalid, ovf, unf});
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] va[6], vb[6], vr[6];
    logic [3:0]  vf[6];
    logic [31:0] res;
    logic [3:0]  fl;
    int lat, nd;
    logic bon, boff;
    va = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h4B000000};
    vr = '{32'h40400000, THIRD,        32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    vf = '{4'b0000,      4'b0000,      4'b1000,      4'b0100,      4'b0010,      4'b0001};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 8'd127, res, fl, lat, nd, bon, boff);
      total++; if (res !== vr[i]) begin bad++; $display("[TB] FAIL vec%0d_result: got %h expected %h", i, res, vr[i]); end
      total++; if (fl !== vf[i]) begin bad++; $display("[TB] FAIL vec%0d_flags: got %b expected %b", i, fl, vf[i]); end
      total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, lat, LAT); end
      total++; if (nd !== 1) begin bad++; $display("[TB] FAIL vec%0d_done_count: got %0d expected 1", i, nd); end
      total++; if (bon !== 1'b1) begin bad++; $display("[TB] FAIL vec%0d_busy_high: got %b expected 1", i, bon); end
      total++; if (boff !== 1'b0) begin bad++; $display("[TB] FAIL vec%0d_busy_low: got %b expected 0", i, boff); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, er;
    logic [3:0]  fl, ef;
    logic [7:0]  bs;
    int lat, nd;
    logic bon, boff;
    for (int i = 0; i < 150; i++) begin
      a  = rand_op();
      b  = rand_op();
      bs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 160)) : 8'd127;
      model(a, b, bs, er, ef);
      run_op(a, b, bs, res, fl, lat, nd, bon, boff);
      total++;
      if (res !== er || fl !== ef) begin
        bad++;
        $display("[TB] FAIL rand%0d %h/%h bias=%0d: got %h flags %b expected %h flags %b", i, a, b, bs, res, fl, er, ef);
      end
      total++;
      if (lat !== LAT || nd !== 1) begin
        bad++;
        $display("[TB] FAIL rand%0d_timing: got lat=%0d dones=%0d expected lat=%0d dones=1", i, lat, nd, LAT);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] er, res;
    logic [3:0]  ef, fl;
    int lat, nd;
    model(32'h3F800000, 32'h40400000, 8'd127, er, ef);
    lat = -1; nd = 0; res = 32'hxxxxxxxx; fl = 4'bxxxx;
    @(negedge clk);
    opa = 32'h3F800000; opb = 32'h40400000; bias = 8'd127; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) begin lat = c; res = result; fl = {dz, invalid, ovf, unf}; end
      end
      if (c == 5) begin opa = 32'h40C00000; opb = 32'h40000000; start = 1'b1; end
      if (c == 6) start = 1'b0;
    end
    total++; if (res !== er) begin bad++; $display("[TB] FAIL ignore_result_model: got %h expected %h", res, er); end
    total++; if (res !== THIRD) begin bad++; $display("[TB] FAIL ignore_result_const: got %h expected %h", res, THIRD); end
    total++; if (fl !== ef) begin bad++; $display("[TB] FAIL ignore_flags: got %b expected %b", fl, ef); end
    total++; if (nd !== 1) begin bad++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", nd); end
    total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, b2, er, res;
    logic [3:0]  ef;
    int dc[$];
    logic [31:0] dr[$];
    a2 = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom())};
    b2 = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom())};
    model(a2, b2, 8'd127, er, ef);
    @(negedge clk);
    opa = 32'h40C00000; opb = 32'h40000000; bias = 8'd127; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 2 * LAT + 10; c++) begin
      @(negedge clk);
      if (done) begin dc.push_back(c); dr.push_back(result); end
      if (c == LAT + 1) begin opa = a2; opb = b2; start = 1'b1; end
      if (c == LAT + 2) start = 1'b0;
    end
    total++;
    if (dc.size() !== 2) begin
      bad++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", dc.size());
    end else begin
      total++;
      if (dc[1] !== 2 * LAT + 1) begin bad++; $display("[TB] FAIL b2b_second_cycle: got %0d expected %0d", dc[1], 2 * LAT + 1); end
      res = dr[1];
      total++;
      if (res !== er) begin bad++; $display("[TB] FAIL b2b_result %h/%h: got %h expected %h", a2, b2, res, er); end
      total++;
      if (dr[0] !== 32'h40400000) begin bad++; $display("[TB] FAIL b2b_first_result: got %h expected 40400000", dr[0]); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic [3:0]  fl;
    int lat, nd;
    logic bon, boff;
    @(negedge clk);
    opa = 32'h40C00000; opb = 32'h40000000; bias = 8'd127; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL abort_result: got %h expected 0", result); end
    run_op(32'h40C00000, 32'h40000000, 8'd127, res, fl, lat, nd, bon, boff);
    total++; if (res !== 32'h40400000) begin bad++; $display("[TB] FAIL abort_restart_result: got %h expected 40400000", res); end
    total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); end
    total++; if (nd !== 1) begin bad++; $display("[TB] FAIL abort_restart_dones: got %0d expected 1", nd); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_spec_vectors();
    test_busy_ignore();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
